vector_exec_unit: RTL and testbench
===================================

// Module: vector_exec_unit
// PURPOSE
//  Multi-cycle, parametrised successor to the fixed 5-lane vector path (vregfile + valu).
//  Owns a vector register file of NVREG registers, each VLEN elements of WIDTH bits.
//  Executes one vector op of programmable length, NLANES elements per cycle.
//  Sits beside the scalar datapath; the controller issues ops with a start/ready handshake.
// PARAMETERS
//  WIDTH   32  element width in bits
//  NLANES  4   elements processed per EXEC cycle (power of 2, divides VLEN)
//  VLEN    16  elements per vector register
//  NVREG   16  number of vector registers (index width RW = $clog2(NVREG))
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low (0 = reset)
//  start       in   1       issue request; accepted when start & ready
//  ready       out  1       1 only in IDLE
//  busy        out  1       1 in EXEC or DONE
//  done        out  1       one-cycle completion pulse
//  op          in   3       000 add, 001 sub, 010 and, 011 orr, 100 eor, 101 mov (d = m)
//  vd,vn,vm    in   RW      destination / source A / source B register
//  len         in   LW      element count; LW = $clog2(VLEN+1)
//  use_scalar  in   1       1: source B = scalar broadcast to every element
//  scalar      in   WIDTH   broadcast operand
//  flags       out  4       NZCV of the last completed op
//  host_we     in   1       host element write (IDLE only)
//  host_addr   in   RW      host register index
//  host_idx    in   $clog2(VLEN) host element index
//  host_wdata  in   WIDTH   host write data
//  host_rdata  out  WIDTH   combinational read of vreg[host_addr][host_idx], always valid
// BEHAVIOUR
//  Reset: state IDLE, ready=1, busy=0, done=0, flags=0, element index=0.
//   Register-file contents are not reset; the bench initialises them via the host port.
//  Reset is asynchronous at any time, including mid-op: state returns to IDLE.
//   Element chunks already written stay written; done does not pulse for the aborted op.
//  FSM states: IDLE -> EXEC -> DONE -> IDLE.
//  IDLE:
//   - start & ready latches op, vd, vn, vm, use_scalar, scalar and len_eff = min(len, VLEN).
//   - Clears idx to 0.
//   - Next state is EXEC, or DONE if len_eff == 0.
//  EXEC, each cycle:
//   - Lane k operates on element e = idx + k.
//   - A lane is active iff e < len_eff; inactive lanes never write.
//   - Results are written to vd at the clock edge; idx += NLANES.
//   - Leave for DONE when idx + NLANES >= len_eff.
//  Latency: start accepted at edge T -> ceil(len_eff/NLANES) EXEC cycles -> done=1 for one cycle -> IDLE.
//  Arithmetic: modulo 2^WIDTH. For sub, C = 1 when no borrow (ARM convention). V = signed overflow.
//  Flags: written on entry to DONE, and only if len_eff > 0 (len_eff=0 leaves flags unchanged).
//   - N = MSB of the last active element's result.
//   - Z = 1 iff every active result is 0.
//   - C, V come from the last active element for add/sub; C=V=0 for logic ops and mov.
//  Aliasing (vd == vn or vd == vm) is legal:
//   - Each chunk reads its elements before that edge's write.
//   - Chunks are disjoint, so in-place results are exact.
//  start while busy is ignored (no queueing). host_we while busy is ignored.
//  host_we & start in the same IDLE cycle: the host write commits at that edge, and EXEC reads see it.
//  Elements e >= len_eff in vd are preserved.
// TESTING (NLANES=4, VLEN=16)
//  1. v1[i]=i, v2[i]=100, add vd=3 len=10 ->
//     v3[0..9]=100+i; v3[10..15] keep preload 0xDEAD; 3 EXEC cycles; done 4 cycles after accept; NZCV=0000.
//  2. v1=v2=0x8000_0000 all, sub len=4 -> v3=0; 1 EXEC cycle; NZCV=0110.
//  3. use_scalar=1, scalar=0xF0, orr vn=1 (v1[i]=i) len=16 -> v4[i]=0xF0|i; NZCV=0000.
//  4. len=0 -> done on the cycle after accept, no writes, flags unchanged.
//     len=20 -> treated as 16, 4 EXEC cycles.
//  5. start and host_we pulsed during EXEC -> both ignored, vregs and op unchanged.
//     add vd=vn=1 (v1[i]=i, v2[i]=1) -> v1[i]=i+1.
//  6. reset low during 2nd EXEC cycle of a len=16 op -> busy=0 and ready=1 immediately;
//     elements 0..3 updated, 4..15 unchanged; no done pulse.

Source files
------------

// File: rtl/vector_exec_unit.sv
// vector_exec_unit: multi-cycle vector execution unit with its own vector
// register file (NVREG x VLEN elements of WIDTH bits).
// Processes NLANES elements per EXEC cycle for one op of programmable length.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   start/ready         issue handshake (accepted when start & ready)
//   busy, done          busy in EXEC/DONE; done is a one-cycle completion pulse
//   op, vd, vn, vm      operation and destination / source register indices
//   len                 element count (clamped to VLEN)
//   use_scalar, scalar  broadcast scalar as source B
//   flags               NZCV of the last completed op
//   host_we/addr/idx/wdata/rdata  host element access (writes only in IDLE)
module vector_exec_unit #(
  parameter int WIDTH  = 32,
  parameter int NLANES = 4,
  parameter int VLEN   = 16,
  parameter int NVREG  = 16,
  localparam int RW    = $clog2(NVREG),
  localparam int LW    = $clog2(VLEN + 1),
  localparam int IW    = $clog2(VLEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  output logic             done,
  input  logic [2:0]       op,
  input  logic [RW-1:0]    vd,
  input  logic [RW-1:0]    vn,
  input  logic [RW-1:0]    vm,
  input  logic [LW-1:0]    len,
  input  logic             use_scalar,
  input  logic [WIDTH-1:0] scalar,
  output logic [3:0]       flags,
  input  logic             host_we,
  input  logic [RW-1:0]    host_addr,
  input  logic [IW-1:0]    host_idx,
  input  logic [WIDTH-1:0] host_wdata,
  output logic [WIDTH-1:0] host_rdata
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   vreg [NVREG][VLEN];

  logic [2:0]         op_q;
  logic [RW-1:0]      vd_q, vn_q, vm_q;
  logic               use_scalar_q;
  logic [WIDTH-1:0]   scalar_q;
  logic [LW-1:0]      len_q;
  logic [LW-1:0]      idx;
  logic               zero_acc;

  logic               accept;
  logic [LW-1:0]      len_eff;
  logic               last_chunk;

  logic [WIDTH-1:0]   res  [NLANES];
  logic               act  [NLANES];
  logic [IW-1:0]      eidx [NLANES];
  logic               chunk_zero;
  logic               n_last, c_last, v_last;

  logic [LW:0]        e;
  logic [WIDTH-1:0]   a, b;
  logic [WIDTH:0]     sum;
  logic               c, v;

  assign accept     = start && (state == IDLE);
  assign len_eff    = (len > LW'(VLEN)) ? LW'(VLEN) : len;
  assign last_chunk = ({1'b0, idx} + (LW+1)'(NLANES)) >= {1'b0, len_q};
  assign host_rdata = vreg[host_addr][host_idx];

  // Lane datapath. Sources are read combinationally from the register file,
  // so a chunk always sees pre-edge values even when vd aliases vn/vm.
  always_comb begin
    chunk_zero = 1'b1;
    n_last     = 1'b0;
    c_last     = 1'b0;
    v_last     = 1'b0;
    e          = '0;
    a          = '0;
    b          = '0;
    sum        = '0;
    c          = 1'b0;
    v          = 1'b0;
    for (int unsigned k = 0; k < NLANES; k++) begin
      e       = {1'b0, idx} + (LW+1)'(k);
      act[k]  = e < {1'b0, len_q};
      eidx[k] = e[IW-1:0];
      a       = vreg[vn_q][eidx[k]];
      b       = use_scalar_q ? scalar_q : vreg[vm_q][eidx[k]];
      c       = 1'b0;
      v       = 1'b0;
      case (op_q)
        3'b000: begin
          sum = {1'b0, a} + {1'b0, b};
          c   = sum[WIDTH];
          v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        3'b001: begin
          // a + ~b + 1: carry out is the ARM "no borrow" flag
          sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
          c   = sum[WIDTH];
          v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        3'b010:  sum = {1'b0, a & b};
        3'b011:  sum = {1'b0, a | b};
        3'b100:  sum = {1'b0, a ^ b};
        3'b101:  sum = {1'b0, b};
        default: sum = '0;
      endcase
      res[k] = sum[WIDTH-1:0];
      if (act[k]) begin
        if (res[k] != '0) chunk_zero = 1'b0;
        // later lanes overwrite, leaving the last active element's flags
        n_last = res[k][WIDTH-1];
        c_last = c;
        v_last = v;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = (len_eff == '0) ? DONE : EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        if (last_chunk) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= '0;
      flags        <= '0;
      zero_acc     <= 1'b1;
      op_q         <= '0;
      vd_q         <= '0;
      vn_q         <= '0;
      vm_q         <= '0;
      use_scalar_q <= 1'b0;
      scalar_q     <= '0;
      len_q        <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q         <= op;
        vd_q         <= vd;
        vn_q         <= vn;
        vm_q         <= vm;
        use_scalar_q <= use_scalar;
        scalar_q     <= scalar;
        len_q        <= len_eff;
        idx          <= '0;
        zero_acc     <= 1'b1;
      end
      if (state == EXEC) begin
        idx      <= idx + LW'(NLANES);
        zero_acc <= zero_acc & chunk_zero;
        if (last_chunk) flags <= {n_last, zero_acc & chunk_zero, c_last, v_last};
      end
    end
  end

  // Register file is not reset. A reset mid-op forces IDLE asynchronously,
  // so no further chunk writes occur after it.
  always_ff @(posedge clk) begin
    if (state == IDLE && host_we) vreg[host_addr][host_idx] <= host_wdata;
    if (state == EXEC) begin
      for (int unsigned k = 0; k < NLANES; k++) begin
        if (act[k]) vreg[vd_q][eidx[k]] <= res[k];
      end
    end
  end

endmodule

// File: tb/tb_vector_exec_unit.sv
// tb_vector_exec_unit: self-checking bench for vector_exec_unit
// (WIDTH=32, NLANES=4, VLEN=16, NVREG=16).
module tb_vector_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ready, busy, done;
  logic [2:0]  op;
  logic [3:0]  vd, vn, vm;
  logic [4:0]  len;
  logic        use_scalar;
  logic [31:0] scalar;
  logic [3:0]  flags;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [3:0]  host_idx;
  logic [31:0] host_wdata, host_rdata;

  vector_exec_unit #(.WIDTH(32), .NLANES(4), .VLEN(16), .NVREG(16)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .busy(busy),
    .done(done), .op(op), .vd(vd), .vn(vn), .vm(vm), .len(len),
    .use_scalar(use_scalar), .scalar(scalar), .flags(flags),
    .host_we(host_we), .host_addr(host_addr), .host_idx(host_idx),
    .host_wdata(host_wdata), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mreg [16][16];
  logic [3:0]  mflags = 4'b0000;

  typedef struct {
    logic [2:0]  op;
    int          vd, vn, vm, len;
    logic        us;
    logic [31:0] scalar;
    int          mode;
    int          exp_exec;
    logic [3:0]  exp_nzcv;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input int r, input int e, output logic [31:0] d);
    @(negedge clk);
    host_addr = 4'(r);
    host_idx  = 4'(e);
    #1 d = host_rdata;
  endtask

  task automatic hw(input int r, input int e, input logic [31:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = 4'(r); host_idx = 4'(e); host_wdata = d;
    mreg[r][e] = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic chk_reg(input int r);
    logic [31:0] d;
    for (int e = 0; e < 16; e++) begin
      rd(r, e, d);
      chk($sformatf("v%0d[%0d]", r, e), d, mreg[r][e]);
    end
  endtask

  // Reference model: whole-vector semantics, sources copied before writing.
  task automatic model_op(input logic [2:0] o, input int d, input int n, input int m,
                          input int l, input logic us, input logic [31:0] s);
    logic [31:0] sa [16];
    logic [31:0] sb [16];
    logic [31:0] r;
    longint full, sres;
    logic fn, fz, fc, fv;
    int le;
    le = (l > 16) ? 16 : l;
    for (int e = 0; e < 16; e++) begin
      sa[e] = mreg[n][e];
      sb[e] = us ? s : mreg[m][e];
    end
    fn = 0; fz = 1; fc = 0; fv = 0;
    for (int e = 0; e < le; e++) begin
      fc = 0; fv = 0;
      case (o)
        3'd0: begin
          full = longint'(sa[e]) + longint'(sb[e]);
          r = full[31:0];
          fc = full >= 64'h1_0000_0000;
          sres = longint'($signed(sa[e])) + longint'($signed(sb[e]));
          fv = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        end
        3'd1: begin
          r = sa[e] - sb[e];
          fc = sa[e] >= sb[e];
          sres = longint'($signed(sa[e])) - longint'($signed(sb[e]));
          fv = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        end
        3'd2: r = sa[e] & sb[e];
        3'd3: r = sa[e] | sb[e];
        3'd4: r = sa[e] ^ sb[e];
        default: r = sb[e];
      endcase
      mreg[d][e] = r;
      fn = r[31];
      if (r != 0) fz = 0;
    end
    if (le > 0) mflags = {fn, fz, fc, fv};
  endtask

  // mode 0: plain; 1: start + host_we pulsed during EXEC; 2: host write in accept cycle
  task automatic issue(input logic [2:0] o, input int d, input int n, input int m,
                       input int l, input logic us, input logic [31:0] s,
                       input int mode, input int exp_cyc);
    int cyc;
    bit seen;
    @(negedge clk);
    chk("ready_idle", 32'(ready), 32'd1);
    op = o; vd = 4'(d); vn = 4'(n); vm = 4'(m); len = 5'(l);
    use_scalar = us; scalar = s; start = 1'b1;
    if (mode == 2) begin
      host_we = 1'b1; host_addr = 4'(n); host_idx = 4'd2; host_wdata = 32'h777;
      mreg[n][2] = 32'h777;
    end
    model_op(o, d, n, m, l, us, s);
    @(negedge clk);
    start = 1'b0; host_we = 1'b0;
    cyc = 0; seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (c > 1) @(negedge clk);
      if (mode == 1 && c == 1) begin
        start = 1'b1; host_we = 1'b1; host_addr = 4'(d); host_idx = 4'd0;
        host_wdata = 32'h1234_5678; op = 3'd1; len = 5'd1;
      end
      if (mode == 1 && c == 2) begin
        start = 1'b0; host_we = 1'b0;
      end
      chk("busy_during_op", 32'(busy), 32'd1);
      if (done) begin
        seen = 1; cyc = c;
      end
    end
    chk("done_latency", 32'(cyc), 32'(exp_cyc));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("ready_after", 32'(ready), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("flags_model", 32'(flags), 32'(mflags));
    chk_reg(d);
  endtask

  function automatic logic [31:0] init_val(input int r, input int e);
    case (r)
      1: return 32'(e);
      2: return 32'd100;
      3: return 32'hDEAD;
      8, 9: return 32'h8000_0000;
      14: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] d;
    int l;
    reset = 1'b0; start = 1'b0; op = '0; vd = '0; vn = '0; vm = '0; len = '0;
    use_scalar = 1'b0; scalar = '0; host_we = 1'b0; host_addr = '0; host_idx = '0;
    host_wdata = '0;

    tbl[0] = '{3'd0, 3, 1, 2, 10, 1'b0, 32'h0, 0, 3, 4'b0000};
    tbl[1] = '{3'd1, 10, 8, 9, 4, 1'b0, 32'h0, 0, 1, 4'b0110};
    tbl[2] = '{3'd0, 11, 1, 2, 0, 1'b0, 32'h0, 0, 0, 4'b0110};
    tbl[3] = '{3'd3, 4, 1, 0, 16, 1'b1, 32'hF0, 0, 4, 4'b0000};
    tbl[4] = '{3'd4, 12, 1, 2, 20, 1'b0, 32'h0, 0, 4, 4'b0000};
    tbl[5] = '{3'd5, 13, 0, 8, 5, 1'b0, 32'h0, 0, 2, 4'b1000};
    tbl[6] = '{3'd0, 1, 1, 14, 16, 1'b0, 32'h0, 1, 4, 4'b0000};
    tbl[7] = '{3'd0, 6, 1, 14, 4, 1'b0, 32'h0, 2, 1, 4'b0000};

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    reset = 1'b1;

    for (int r = 0; r < 16; r++)
      for (int e = 0; e < 16; e++) hw(r, e, init_val(r, e));

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].op, tbl[i].vd, tbl[i].vn, tbl[i].vm, tbl[i].len, tbl[i].us,
            tbl[i].scalar, tbl[i].mode, tbl[i].exp_exec + 1);
      chk($sformatf("tbl%0d_nzcv", i), 32'(flags), 32'(tbl[i].exp_nzcv));
    end
    rd(3, 9, d);  chk("t1_v3_9", d, 32'd109);
    rd(3, 10, d); chk("t1_v3_10_kept", d, 32'hDEAD);
    rd(4, 7, d);  chk("t3_v4_7", d, 32'hF7);
    rd(1, 5, d);  chk("t5_v1_5", d, 32'd6);
    rd(6, 2, d);  chk("t7_v6_2", d, 32'h778);
    rd(11, 0, d); chk("len0_v11_0", d, mreg[11][0]);

    // Reset during the second EXEC cycle of a 16-element op.
    @(negedge clk);
    op = 3'd0; vd = 4'd7; vn = 4'd1; vm = 4'd14; len = 5'd16; use_scalar = 1'b0;
    start = 1'b1;
    for (int e = 0; e < 4; e++) mreg[7][e] = mreg[1][e] + mreg[14][e];
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mflags = 4'b0000;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_flags", 32'(flags), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b1;
      chk("abort_no_done", 32'(done), 32'd0);
    end
    chk_reg(7);

    // Randomised ops against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        hw($urandom_range(0, 15), $urandom_range(0, 15), $urandom);
      l = $urandom_range(0, 20);
      issue(3'($urandom_range(0, 5)), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), l, 1'($urandom_range(0, 1)), $urandom, 0,
            (((l > 16) ? 16 : l) + 3) / 4 + 1);
    end

    for (int r = 0; r < 16; r++) chk_reg(r);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
